// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with data priority, fetch anti-starvation, and a bounded-wait watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_IF,
    output logic              stall_MEM,
    output logic              tmo_err
);

    localparam int WD_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic              last_gnt_data_r;
    logic              if_seen_r;
    logic [WD_W-1:0]   wdog_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_valid_r;
    logic              dm_valid_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              tmo_err_r;
    logic              gnt_data_s;
    logic              gnt_inst_s;

    // Grant choice: data wins unless fetch already waited through the last data grant.
    always_comb begin
        gnt_data_s = 1'b0;
        gnt_inst_s = 1'b0;
        if (dm_req && !(if_req && last_gnt_data_r && if_seen_r)) begin
            gnt_data_s = 1'b1;
        end else if (if_req) begin
            gnt_inst_s = 1'b1;
        end else begin
            gnt_data_s = 1'b0;
            gnt_inst_s = 1'b0;
        end
    end

    // Arbiter FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            last_gnt_data_r <= 1'b1;
            if_seen_r       <= 1'b0;
            wdog_r          <= {WD_W{1'b0}};
            if_rdata_r      <= {DATA_W{1'b0}};
            dm_rdata_r      <= {DATA_W{1'b0}};
            if_valid_r      <= 1'b0;
            dm_valid_r      <= 1'b0;
            mem_req_r       <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wdata_r     <= {DATA_W{1'b0}};
            tmo_err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_data_s) begin
                        state_r         <= BUSY_D;
                        mem_req_r       <= 1'b1;
                        mem_we_r        <= dm_we;
                        mem_addr_r      <= dm_addr;
                        mem_wdata_r     <= dm_wdata;
                        last_gnt_data_r <= 1'b1;
                        if_seen_r       <= if_req;
                        wdog_r          <= {WD_W{1'b0}};
                    end else if (gnt_inst_s) begin
                        state_r         <= BUSY_I;
                        mem_req_r       <= 1'b1;
                        mem_we_r        <= 1'b0;
                        mem_addr_r      <= if_addr;
                        mem_wdata_r     <= {DATA_W{1'b0}};
                        last_gnt_data_r <= 1'b0;
                        if_seen_r       <= 1'b0;
                        wdog_r          <= {WD_W{1'b0}};
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (state_r == BUSY_D) begin
                        if_seen_r <= if_seen_r | if_req;
                    end
                    if (mem_ready || (wdog_r == WD_LAST)) begin
                        state_r   <= DONE;
                        mem_req_r <= 1'b0;
                        if (!mem_ready) begin
                            tmo_err_r <= 1'b1;
                        end
                        if (state_r == BUSY_D) begin
                            dm_valid_r <= 1'b1;
                            // Stores and aborts both return zero on the data port.
                            dm_rdata_r <= (mem_ready && !mem_we_r) ? mem_rdata : {DATA_W{1'b0}};
                        end else begin
                            if_valid_r <= 1'b1;
                            if_rdata_r <= mem_ready ? mem_rdata : {DATA_W{1'b0}};
                        end
                    end else begin
                        wdog_r <= wdog_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    if_valid_r <= 1'b0;
                    dm_valid_r <= 1'b0;
                    if (last_gnt_data_r) begin
                        if_seen_r <= if_seen_r | if_req;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    mem_req_r  <= 1'b0;
                    if_valid_r <= 1'b0;
                    dm_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_valid  = if_valid_r;
    assign dm_valid  = dm_valid_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign tmo_err   = tmo_err_r;
    assign stall_IF  = if_req & ~if_valid_r;
    assign stall_MEM = dm_req & ~dm_valid_r;

endmodule
